hevc_subpel_interp_2d: RTL and testbench
========================================

Name: hevc_subpel_interp_2d

Overview:
- Streaming separable 2-D HEVC luma sub-pixel interpolator, parametrised in block size and pixel width.
- Consumes one padded reference row per beat: BLK_W+7 integer pixels.
- Emits one BLK_W-pixel interpolated row per beat, at the run-time-selected quarter-pel position (frac_x, frac_y).
- Sits between the integer reference-row fetch and motion-compensation output buffering. One block per start pulse, BLK_H output rows.

Parameters:
- BLK_W, 8, output block width in pixels
- BLK_H, 8, output block height in rows
- PIX_W, 8, pixel bit width (8 only verified; shifts below fixed for 8)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  begin new block; sampled only in IDLE
- frac_x  in  2  horizontal phase 0..3 (0 = integer, 1 = 1/4, 2 = 1/2, 3 = 3/4), latched at start
- frac_y  in  2  vertical phase, same encoding, latched at start
- in_valid  in  1  in_row valid
- in_ready  out  1  row accepted when in_valid && in_ready
- in_row  in  (BLK_W+7)*PIX_W  reference row; pixel i at [i*PIX_W +: PIX_W], i = 0 is leftmost (col -3)
- row_idx  out  8  index (0..BLK_H+6) of next reference row expected
- out_valid  out  1  out_row valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_row  out  BLK_W*OUT_W  interpolated row; OUT_W = PIX_W, or 16 under BIPRED_OUT_EN
- out_last  out  1  qualifies final row of block
- busy  out  1  high from start acceptance until last output accepted
- done  out  1  one-cycle pulse when last output row accepted

Behaviour:
- Reset (rst low, async): state IDLE; in_ready 0, out_valid 0, out_last 0, busy 0, done 0, row_idx 0, out_row 0; line buffer cleared.
- Taps, indices 0..7:
  - phase 0: {0,0,0,64,0,0,0,0}
  - phase 1: {-1,4,-10,58,17,-5,1,0}
  - phase 2: {-1,4,-11,40,40,-11,4,-1}
  - phase 3: {0,1,-5,17,58,-10,4,-1}
- Horizontal stage (combinational, on in_row):
  - h[j] = sum over t of cx[t] * in_row pixel (j+t), j = 0..BLK_W-1.
  - Signed 16-bit, no shift; the coefficient range guarantees it fits.
- Line buffer: 7 rows of BLK_W signed 16-bit h values, shifted on each accepted input row.
- Vertical stage:
  - v[j] = sum over t of cy[t] * hrow(t)[j], where hrow(7) is the current row's h and hrow(0..6) are the buffer, oldest first.
  - Signed 24-bit accumulator.
  - Output = clip((v + 2048) >>> 12, 0, 2^PIX_W - 1).
- States:
  - IDLE: in_ready 0. On start, latch frac, clear counters, assert busy, go to FILL. start in any other state is ignored.
  - FILL: accept rows 0..6 into the buffer only; no output. After row 6, go to RUN.
  - RUN: each accepted row 7..BLK_H+6 loads out_row/out_valid on the next edge (latency 1 cycle). The same edge shifts the buffer. After row BLK_H+6 is accepted, go to DRAIN.
  - DRAIN: in_ready 0. When the last output is accepted, pulse done, drop busy, go to IDLE.
- in_ready = (FILL) || (RUN && (!out_valid || out_ready)). The buffer never overwrites an unaccepted output.
- out_row is held stable while out_valid && !out_ready.
- out_last asserts with the row produced from input row BLK_H+6.
- row_idx = count of accepted input rows in the current block; 0 in IDLE.
- Simultaneous output accept and new input accept in RUN: out_valid stays 1 and out_row takes the new value.
- Reset mid-block aborts immediately; no done pulse.

Optional Feature:
- Macro: HEVC_SUBPEL_BIPRED_OUT_EN.
- Defined: OUT_W = 16; output = (v >>> 6) as signed 16-bit, unclipped (high-precision intermediate for bi-prediction averaging). Rounding offset and clip are removed.
- Undefined: clipped PIX_W output as in Behaviour.

Decomposition:
- Package hevc_subpel_pkg holds:
  - the 4x8 luma coefficient table as signed 8-bit constants
  - phase encoding constants
  - FSM state enum
  - accumulator width constants (H_W = 16, V_W = 24)
- Sub-module hevc_fir8: generic 8-tap signed multiply-accumulate with coefficient-phase select. Instantiated BLK_W times horizontally and BLK_W times vertically via generate.

Test Plan:
- Flat block, all pixels 100, each of the 16 frac combinations -> every output pixel 100, out_last on row 7, done pulse, busy drops.
- Integer phase (0,0), pixel = (r*16 + c) mod 256 -> out[k][j] = in[k+3][j+3] for all k, j < 8.
- frac = (2,0), rows alternating 0/255 by column (even = 0) -> every output pixel 128.
- Clip: frac_x = 1, window {255,0,255,0,0,255,0,0} in every row -> 0.
- Clip: frac_x = 1, window {0,255,0,255,255,0,255,255} in every row -> 255.
- Backpressure: out_ready low for 5 cycles mid-RUN -> in_ready 0, out_row stable, no row lost; all 8 rows delivered in order.
- Reset mid-RUN after 10 rows: rst low 1 cycle -> state IDLE, out_valid 0, row_idx 0, no done. A following start completes normally.
- With HEVC_SUBPEL_BIPRED_OUT_EN, flat 100, frac (1,3) -> every output 16'd6400.

Source files
------------

// File: rtl/hevc_subpel_pkg.sv
// Shared constants for the HEVC luma sub-pel interpolator: 8-tap luma filter table,
// phase encoding, controller states and datapath accumulator widths.
package hevc_subpel_pkg;

  localparam int H_W = 16;
  localparam int V_W = 24;

  localparam logic [1:0] PH_INT  = 2'd0;
  localparam logic [1:0] PH_QTR  = 2'd1;
  localparam logic [1:0] PH_HALF = 2'd2;
  localparam logic [1:0] PH_3QTR = 2'd3;

  // Indexed [phase][tap]; tap 3 is the co-located integer sample.
  localparam logic signed [7:0] LUMA_COEF [4][8] = '{
    '{8'sd0,  8'sd0, 8'sd0,   8'sd64, 8'sd0,  8'sd0,   8'sd0, 8'sd0},
    '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5,  8'sd1, 8'sd0},
    '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1},
    '{8'sd0,  8'sd1, -8'sd5,  8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1}
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/hevc_fir8.sv
// Generic 8-tap signed MAC; coefficients come from the luma table row chosen by phase_i.
module hevc_fir8
  import hevc_subpel_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24
) (
  input  logic [1:0]              phase_i,
  input  logic [8*IN_W-1:0]       samp_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int t = 0; t < 8; t++) begin
      acc = acc + ACC_W'(LUMA_COEF[phase_i][t]) * ACC_W'($signed(samp_i[t*IN_W +: IN_W]));
    end
  end

  assign acc_o = acc;

endmodule

// File: rtl/hevc_subpel_interp_2d.sv
// Streaming separable 2-D HEVC luma quarter-pel interpolator, one row in / one row out.
// Optional macro HEVC_SUBPEL_BIPRED_OUT_EN selects unclipped 16-bit (v >>> 6) output.
module hevc_subpel_interp_2d
  import hevc_subpel_pkg::*;
#(
  parameter int BLK_W = 8,
  parameter int BLK_H = 8,
  parameter int PIX_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 frac_x,
  input  logic [1:0]                 frac_y,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [(BLK_W+7)*PIX_W-1:0] in_row,
  output logic [7:0]                 row_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef HEVC_SUBPEL_BIPRED_OUT_EN
  output logic [BLK_W*16-1:0]        out_row,
`else
  output logic [BLK_W*PIX_W-1:0]     out_row,
`endif
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

`ifdef HEVC_SUBPEL_BIPRED_OUT_EN
  localparam int OUT_W = 16;
`else
  localparam int OUT_W = PIX_W;
`endif
  localparam logic [7:0] LAST_ROW = 8'(BLK_H + 6);
  localparam logic [7:0] FILL_END = 8'd6;

  state_e                   state_q;
  logic [1:0]               fx_q, fy_q;
  logic [7:0]               cnt_q;
  logic signed [H_W-1:0]    lb_q [7][BLK_W];
  logic [BLK_W*OUT_W-1:0]   out_row_q, out_row_d;
  logic                     out_valid_q, out_last_q, busy_q, done_q;
  logic signed [H_W-1:0]    h [BLK_W];
  logic signed [V_W-1:0]    v [BLK_W];
  logic                     in_acc, out_acc;

  function automatic logic [OUT_W-1:0] fmt_out(input logic signed [V_W-1:0] acc);
    logic signed [V_W-1:0] r;
`ifdef HEVC_SUBPEL_BIPRED_OUT_EN
    r = acc >>> 6;
    return OUT_W'(r);
`else
    r = (acc + V_W'(2048)) >>> 12;
    if (r < 0)
      return '0;
    else if (r > V_W'((1 << PIX_W) - 1))
      return {OUT_W{1'b1}};
    else
      return OUT_W'(r);
`endif
  endfunction

  assign in_ready = (state_q == ST_FILL) ||
                    ((state_q == ST_RUN) && (!out_valid_q || out_ready));
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid_q && out_ready;

  // Horizontal pass on the incoming row, vertical pass over buffer + current row
  for (genvar j = 0; j < BLK_W; j++) begin : g_col
    logic [8*H_W-1:0] hsamp, vsamp;
    for (genvar t = 0; t < 8; t++) begin : g_tap
      assign hsamp[t*H_W +: H_W] = H_W'(in_row[(j+t)*PIX_W +: PIX_W]);
      if (t < 7) begin : g_buf
        assign vsamp[t*H_W +: H_W] = lb_q[t][j];
      end else begin : g_cur
        assign vsamp[t*H_W +: H_W] = h[j];
      end
    end

    hevc_fir8 #(.IN_W(H_W), .ACC_W(H_W)) u_fir_h (
      .phase_i (fx_q),
      .samp_i  (hsamp),
      .acc_o   (h[j])
    );

    hevc_fir8 #(.IN_W(H_W), .ACC_W(V_W)) u_fir_v (
      .phase_i (fy_q),
      .samp_i  (vsamp),
      .acc_o   (v[j])
    );

    assign out_row_d[j*OUT_W +: OUT_W] = fmt_out(v[j]);
  end

  // Block controller, line buffer and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fx_q        <= PH_INT;
      fy_q        <= PH_INT;
      cnt_q       <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 7; i++)
        for (int j = 0; j < BLK_W; j++)
          lb_q[i][j] <= '0;
    end else begin
      done_q <= 1'b0;
      if (in_acc) begin
        for (int j = 0; j < BLK_W; j++) begin
          for (int i = 0; i < 6; i++)
            lb_q[i][j] <= lb_q[i+1][j];
          lb_q[6][j] <= h[j];
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            fx_q    <= frac_x;
            fy_q    <= frac_y;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (in_acc) begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == FILL_END)
              state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (out_acc) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
          if (in_acc) begin
            cnt_q       <= cnt_q + 8'd1;
            out_row_q   <= out_row_d;
            out_valid_q <= 1'b1;
            out_last_q  <= (cnt_q == LAST_ROW);
            if (cnt_q == LAST_ROW)
              state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_acc) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign row_idx   = cnt_q;
  assign out_row   = out_row_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_hevc_subpel_interp_2d.sv
// Randomised bench for hevc_subpel_interp_2d against a plain-arithmetic 2-D filter model.
module tb_hevc_subpel_interp_2d;

  localparam int BLK_W = 8;
  localparam int BLK_H = 8;
  localparam int PIX_W = 8;
  localparam int NROWS = BLK_H + 7;
  localparam int NCOLS = BLK_W + 7;
`ifdef HEVC_SUBPEL_BIPRED_OUT_EN
  localparam int OUT_W = 16;
  localparam int FLAT_EXP = 6400;
  localparam int SPEC_CONST = 0;
`else
  localparam int OUT_W = PIX_W;
  localparam int FLAT_EXP = 100;
  localparam int SPEC_CONST = 1;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [1:0]               frac_x = '0, frac_y = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [NCOLS*PIX_W-1:0]   in_row = '0;
  logic [7:0]               row_idx;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [BLK_W*OUT_W-1:0]   out_row;
  logic                     out_last, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  int coef [4][8] = '{
    '{0, 0, 0, 64, 0, 0, 0, 0},
    '{-1, 4, -10, 58, 17, -5, 1, 0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{0, 1, -5, 17, 58, -10, 4, -1}
  };
  int img [NROWS][NCOLS];
  int win_lo [8] = '{255, 0, 255, 0, 0, 255, 0, 0};
  int win_hi [8] = '{0, 255, 0, 255, 255, 0, 255, 255};
  logic [BLK_W*OUT_W-1:0] exp_rows [BLK_H];

  hevc_subpel_interp_2d #(.BLK_W(BLK_W), .BLK_H(BLK_H), .PIX_W(PIX_W)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .start     (start),
    .frac_x    (frac_x),
    .frac_y    (frac_y),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .row_idx   (row_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int fmt_pix(input int v);
`ifdef HEVC_SUBPEL_BIPRED_OUT_EN
    return (v >>> 6) & 16'hFFFF;
`else
    int r;
    r = (v + 2048) >>> 12;
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
`endif
  endfunction

  task automatic build_model(input int fx, input int fy);
    for (int k = 0; k < BLK_H; k++) begin
      for (int j = 0; j < BLK_W; j++) begin
        int v;
        v = 0;
        for (int t = 0; t < 8; t++) begin
          int hs;
          hs = 0;
          for (int u = 0; u < 8; u++) hs += coef[fx][u] * img[k+t][j+u];
          v += coef[fy][t] * hs;
        end
        exp_rows[k][j*OUT_W +: OUT_W] = OUT_W'(fmt_pix(v));
      end
    end
  endtask

  // pat: 0 flat 100, 1 ramp, 2 alternating 0/255, 3 clip-low window, 4 clip-high window, 5 random
  task automatic fill_img(input int pat);
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < NCOLS; c++)
        case (pat)
          0: img[r][c] = 100;
          1: img[r][c] = (r * 16 + c) % 256;
          2: img[r][c] = (c % 2 == 0) ? 0 : 255;
          3: img[r][c] = win_lo[c % 8];
          4: img[r][c] = win_hi[c % 8];
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endtask

  task automatic drive_row(input int r);
    for (int i = 0; i < NCOLS; i++) in_row[i*PIX_W +: PIX_W] = PIX_W'(img[r][i]);
  endtask

  // rmode: 0 always ready, 1 random ready, 2 five-cycle stall on third output
  task automatic run_block(input int fx, input int fy, input int pat, input int rmode,
                           input int exp0, input int ident);
    int sent, nout, stall, cyc;
    logic hold, in_acc, out_acc;
    logic [BLK_W*OUT_W-1:0] prev;
    fill_img(pat);
    build_model(fx, fy);
    @(negedge clk);
    frac_x = 2'(fx); frac_y = 2'(fy); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", busy, 1'b1);
    sent = 0; nout = 0; stall = 0; cyc = 0; hold = 1'b0; prev = '0;
    while (nout < BLK_H && cyc < 2000) begin
      in_valid = (sent < NROWS) && (rmode != 1 || $urandom_range(0, 3) != 0);
      if (sent < NROWS) drive_row(sent);
      if (rmode == 0) out_ready = 1'b1;
      else if (rmode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else begin
        out_ready = !(out_valid && nout == 2 && stall < 5);
        if (!out_ready) stall++;
      end
      #1;
      if (hold) chk("hold_stable", out_row, prev);
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", in_ready, 1'b0);
        hold = 1'b1; prev = out_row;
      end else hold = 1'b0;
      in_acc  = in_valid && in_ready;
      out_acc = out_valid && out_ready;
      if (in_acc) chk("row_idx", row_idx, 128'(sent));
      if (out_acc) begin
        chk("row", out_row, exp_rows[nout]);
        if (exp0 >= 0) chk("pix0", out_row[OUT_W-1:0], 128'(exp0));
        if (ident != 0)
          for (int j = 0; j < BLK_W; j++)
            chk("ident", out_row[j*OUT_W +: OUT_W], 128'(img[nout+3][j+3]));
        chk("last", out_last, (nout == BLK_H - 1));
      end
      @(posedge clk);
      if (in_acc) sent++;
      if (out_acc) nout++;
      if (out_acc && nout == BLK_H) begin
        #1;
        chk("done", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        chk("idx_end", row_idx, 128'(0));
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) chk("timeout", 128'(nout), 128'(BLK_H));
    in_valid = 1'b0;
    chk("sent_all", 128'(sent), 128'(NROWS));
  endtask

  task automatic reset_mid_run();
    int sent, cyc;
    fill_img(5);
    @(negedge clk);
    frac_x = 2'd1; frac_y = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    sent = 0; cyc = 0;
    while (sent < 10 && cyc < 100) begin
      in_valid = 1'b1; drive_row(sent);
      #1;
      if (in_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    chk("pre_rst_valid", out_valid, 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_row_idx", row_idx, 128'(0));
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_no_done", done, 1'b0);
      chk("rst_idle_ready", in_ready, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("r_in_ready", in_ready, 1'b0);
    chk("r_out_valid", out_valid, 1'b0);
    chk("r_out_last", out_last, 1'b0);
    chk("r_busy", busy, 1'b0);
    chk("r_done", done, 1'b0);
    chk("r_row_idx", row_idx, 128'(0));
    chk("r_out_row", out_row, 128'(0));
    rst_n = 1'b1;

    for (int f = 0; f < 16; f++) run_block(f / 4, f % 4, 0, (f % 3 == 0) ? 1 : 0, FLAT_EXP, 0);
    run_block(0, 0, 1, 0, -1, 1);
    run_block(2, 0, 2, 0, SPEC_CONST ? 128 : -1, 0);
    run_block(1, 0, 3, 0, SPEC_CONST ? 0 : -1, 0);
    run_block(1, 0, 4, 0, SPEC_CONST ? 255 : -1, 0);
    run_block(1, 3, 0, 0, FLAT_EXP, 0);
    run_block(2, 3, 5, 2, -1, 0);
    reset_mid_run();
    run_block(3, 1, 5, 0, -1, 0);
    for (int n = 0; n < 6; n++)
      run_block(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 5, 1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
